// File: rtl/motor_dense_pkg.sv
// Shared types, constants and quantisation for the ap_fixed<21,7> dense layer.
// Define MOTOR_DENSE_SAT_EN to saturate instead of wrap on output overflow.
package motor_dense_pkg;

    localparam int unsigned D_W    = 21;
    localparam int unsigned I_W    = 7;
    localparam int unsigned F_W    = 14;
    localparam int unsigned PROD_W = 42;

    localparam int unsigned N_IN_DEF  = 4;
    localparam int unsigned N_OUT_DEF = 3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((32'd1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    // Headroom for N_IN products plus the bias term.
    localparam int unsigned ACC_W = PROD_W + clog2(N_IN_DEF + 1);

    typedef enum logic [2:0] {
        StIdle,
        StBias,
        StMac,
        StStore,
        StDone
    } state_e;

    // w[i][j] at [21*(i*N_OUT+j) +: 21], highest index first.
    localparam logic [N_IN_DEF*N_OUT_DEF*D_W-1:0] W_DEFAULT = {
        21'h1FD2A4, 21'h0013B8, 21'h002F10,
        21'h001A3C, 21'h1FE6C0, 21'h000944,
        21'h1FF1D8, 21'h003562, 21'h1FCB0E,
        21'h0027A0, 21'h1FF83C, 21'h0011F6
    };

    localparam logic [N_OUT_DEF*D_W-1:0] B_DEFAULT = {
        21'h1FFA10, 21'h000C48, 21'h0003E2
    };

    function automatic logic [D_W-1:0] quantise(input logic [ACC_W-1:0] acc);
        logic [D_W-1:0] q;
        q = acc[F_W+D_W-1:F_W];
`ifdef MOTOR_DENSE_SAT_EN
        if (acc[ACC_W-1:F_W+D_W-1] != {(ACC_W-F_W-D_W+1){acc[ACC_W-1]}}) begin
            q = acc[ACC_W-1] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
        end
`endif
        return q;
    endfunction

endpackage

// File: rtl/motor_dense_mac.sv
// Single signed 21x21 multiplier feeding a 45-bit accumulator; output is the
// quantised accumulator (wrap, or saturate under MOTOR_DENSE_SAT_EN).
module motor_dense_mac
    import motor_dense_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  logic           load_i,
    input  logic           acc_en_i,
    input  logic [D_W-1:0] bias_i,
    input  logic [D_W-1:0] a_i,
    input  logic [D_W-1:0] b_i,
    output logic [D_W-1:0] q_o
);

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;

    assign prod = $signed(a_i) * $signed(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            // Bias aligned to the 28-bit product fraction.
            acc_d = {{(ACC_W-D_W-F_W){bias_i[D_W-1]}}, bias_i, {F_W{1'b0}}};
        end else if (acc_en_i) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q_o = quantise(acc_q);

endmodule

// File: rtl/motor_dense_seq_21_7.sv
// Time-multiplexed dense layer with ap_ctrl_hs handshake; one MAC per cycle.
// Output overflow wraps unless MOTOR_DENSE_SAT_EN is defined.
module motor_dense_seq_21_7
    import motor_dense_pkg::*;
#(
    parameter int unsigned                N_IN   = N_IN_DEF,
    parameter int unsigned                N_OUT  = N_OUT_DEF,
    parameter logic [N_IN*N_OUT*D_W-1:0]  W_INIT = W_DEFAULT,
    parameter logic [N_OUT*D_W-1:0]       B_INIT = B_DEFAULT
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  ap_ready,
    input  logic [N_IN*D_W-1:0]   x_in,
    output logic [N_OUT*D_W-1:0]  y_out
);

    localparam int unsigned IW = (N_IN > 1) ? clog2(N_IN) : 1;
    localparam int unsigned JW = (N_OUT > 1) ? clog2(N_OUT) : 1;

    state_e                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;
    logic [N_IN*D_W-1:0]    x_q, x_d;
    logic [N_OUT*D_W-1:0]   y_q, y_d;

    logic                   mac_clear, mac_load, mac_acc;
    logic [D_W-1:0]         mac_a, mac_b, mac_bias, mac_q;

    assign mac_a    = x_q[D_W*i_q +: D_W];
    assign mac_b    = W_INIT[D_W*(i_q*N_OUT + j_q) +: D_W];
    assign mac_bias = B_INIT[D_W*j_q +: D_W];

    motor_dense_mac u_mac (
        .clk_i    (ap_clk),
        .rst_i    (ap_rst),
        .clear_i  (mac_clear),
        .load_i   (mac_load),
        .acc_en_i (mac_acc),
        .bias_i   (mac_bias),
        .a_i      (mac_a),
        .b_i      (mac_b),
        .q_o      (mac_q)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        x_d       = x_q;
        y_d       = y_q;
        mac_clear = 1'b0;
        mac_load  = 1'b0;
        mac_acc   = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ap_idle   = (state_q == StIdle);
        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    x_d       = x_in;
                    j_d       = '0;
                    mac_clear = 1'b1;
                    state_d   = StBias;
                end
            end
            StBias: begin
                mac_load = 1'b1;
                i_d      = '0;
                state_d  = StMac;
            end
            StMac: begin
                mac_acc = 1'b1;
                if (i_q == IW'(N_IN - 1)) begin
                    state_d = StStore;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StStore: begin
                y_d[D_W*j_q +: D_W] = mac_q;
                if (j_q == JW'(N_OUT - 1)) begin
                    state_d = StDone;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = StBias;
                end
            end
            StDone: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: tb/tb_motor_dense_seq_21_7.sv
// Directed bench: four layer instances with distinct weight/bias sets share
// one handshake and input bus; expected values are hand-computed fixed-point.
module tb_motor_dense_seq_21_7;

    localparam int unsigned NI = 4;
    localparam int unsigned NO = 3;
    localparam int unsigned DW = 21;

    function automatic logic [NI*NO*DW-1:0] fill_w(input logic [DW-1:0] diag,
                                                   input logic [DW-1:0] off);
        logic [NI*NO*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NO; j++) begin
                r[DW*(i*NO+j) +: DW] = (i == j) ? diag : off;
            end
        end
        return r;
    endfunction

    localparam logic [NI*NO*DW-1:0] W_ID   = fill_w(21'h04000, 21'h00000);
    localparam logic [NI*NO*DW-1:0] W_HALF = fill_w(21'h02000, 21'h02000);
    localparam logic [NI*NO*DW-1:0] W_ONE  = fill_w(21'h04000, 21'h04000);
    localparam logic [NI*NO*DW-1:0] W_ZERO = '0;
    localparam logic [NO*DW-1:0]    B_ZERO = '0;
    localparam logic [NO*DW-1:0]    B_MIX  = {21'h000000, 21'h003000, 21'h1FE000};

    logic              ap_clk, ap_rst, ap_start;
    logic [NI*DW-1:0]  x_in;
    logic              idle_id, done_id, ready_id;
    logic              idle_hf, done_hf, ready_hf;
    logic              idle_on, done_on, ready_on;
    logic              idle_bs, done_bs, ready_bs;
    logic [NO*DW-1:0]  y_id, y_hf, y_on, y_bs;

    int n_tests = 0;
    int n_fail  = 0;

    motor_dense_seq_21_7 #(.N_IN(NI), .N_OUT(NO), .W_INIT(W_ID), .B_INIT(B_ZERO)) u_id (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(idle_id),
        .ap_done(done_id), .ap_ready(ready_id), .x_in(x_in), .y_out(y_id)
    );
    motor_dense_seq_21_7 #(.N_IN(NI), .N_OUT(NO), .W_INIT(W_HALF), .B_INIT(B_ZERO)) u_hf (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(idle_hf),
        .ap_done(done_hf), .ap_ready(ready_hf), .x_in(x_in), .y_out(y_hf)
    );
    motor_dense_seq_21_7 #(.N_IN(NI), .N_OUT(NO), .W_INIT(W_ONE), .B_INIT(B_ZERO)) u_on (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(idle_on),
        .ap_done(done_on), .ap_ready(ready_on), .x_in(x_in), .y_out(y_on)
    );
    motor_dense_seq_21_7 #(.N_IN(NI), .N_OUT(NO), .W_INIT(W_ZERO), .B_INIT(B_MIX)) u_bs (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(idle_bs),
        .ap_done(done_bs), .ap_ready(ready_bs), .x_in(x_in), .y_out(y_bs)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [NO*DW-1:0] y, input int j);
        return y[DW*j +: DW];
    endfunction

    function automatic logic [NI*DW-1:0] pack_x(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                                input logic [DW-1:0] a2, input logic [DW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [NO*DW-1:0] rep3(input logic [DW-1:0] v);
        return {v, v, v};
    endfunction

    // Start one computation and watch 45 cycles; optional stray start pulses
    // and an input change after capture.
    task automatic run(input logic [NI*DW-1:0] xv, input int pa, input int pb, input int xchg,
                       output int lat, output int ndone, output int nready_bad);
        @(posedge ap_clk); #1;
        x_in     = xv;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start   = 1'b0;
        lat        = 0;
        ndone      = 0;
        nready_bad = 0;
        for (int n = 1; n <= 45; n++) begin
            if (done_id) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            if (done_id !== ready_id) nready_bad++;
            ap_start = (n == pa) || (n == pb);
            if (n == xchg) x_in = ~xv;
            @(posedge ap_clk); #1;
        end
        ap_start = 1'b0;
    endtask

    logic [NI*DW-1:0] x_t1;
    int lat, nd, nrb;
    int t_done [3];
    int k, nd_rst;

    initial begin
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        x_in     = '0;
        x_t1     = pack_x(21'h006000, 21'h1F8000, 21'h001000, 21'h00C000);
        #1;
        check("reset_idle", idle_id, 1);
        check("reset_done", done_id, 0);
        check("reset_ready", ready_id, 0);
        check("reset_y", y_id, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;

        // Identity weights and mixed-sign inputs.
        run(x_t1, -1, -1, -1, lat, nd, nrb);
        check("t1_latency", lat, 19);
        check("t1_ndone", nd, 1);
        check("t1_ready_coinc", nrb, 0);
        check("t1_id_y0", lane(y_id, 0), 21'h006000);
        check("t1_id_y1", lane(y_id, 1), 21'h1F8000);
        check("t1_id_y2", lane(y_id, 2), 21'h001000);
        check("t1_half", y_hf, rep3(21'h005800));
        check("t1_one", y_on, rep3(21'h00B000));
        check("t1_idle_after", idle_id, 1);

        // Truncation toward -inf.
        run(pack_x(21'h000001, 0, 0, 0), -1, -1, -1, lat, nd, nrb);
        check("t2_half_pos", y_hf, 0);
        check("t2_id_pos", y_id, {21'h0, 21'h0, 21'h000001});
        run(pack_x(21'h1FFFFF, 0, 0, 0), -1, -1, -1, lat, nd, nrb);
        check("t2_half_neg", y_hf, rep3(21'h1FFFFF));
        check("t2_one_neg", y_on, rep3(21'h1FFFFF));

        // Integer overflow, positive and negative.
        run(pack_x(21'h0FC000, 21'h0FC000, 21'h0FC000, 21'h0FC000), -1, -1, -1, lat, nd, nrb);
        check("t3_id", y_id, rep3(21'h0FC000));
`ifdef MOTOR_DENSE_SAT_EN
        check("t3_one_pos", y_on, rep3(21'h0FFFFF));
        check("t3_half_pos", y_hf, rep3(21'h0FFFFF));
`else
        check("t3_one_pos", y_on, rep3(21'h1F0000));
        check("t3_half_pos", y_hf, rep3(21'h1F8000));
`endif
        run(pack_x(21'h100000, 21'h100000, 21'h100000, 21'h100000), -1, -1, -1, lat, nd, nrb);
`ifdef MOTOR_DENSE_SAT_EN
        check("t3_one_neg", y_on, rep3(21'h100000));
        check("t3_half_neg", y_hf, rep3(21'h100000));
`else
        check("t3_one_neg", y_on, 0);
        check("t3_half_neg", y_hf, 0);
`endif

        // Bias only.
        run('0, -1, -1, -1, lat, nd, nrb);
        check("t4_bias", y_bs, {21'h000000, 21'h003000, 21'h1FE000});
        check("t4_id_zero", y_id, 0);

        // Stray start pulses and post-capture input change.
        run(x_t1, 3, 10, 2, lat, nd, nrb);
        check("t5_latency", lat, 19);
        check("t5_ndone", nd, 1);
        check("t5_id_y", y_id, {21'h001000, 21'h1F8000, 21'h006000});
        check("t5_one", y_on, rep3(21'h00B000));

        // Start held high: back-to-back runs.
        @(posedge ap_clk); #1;
        x_in     = x_t1;
        ap_start = 1'b1;
        k        = 0;
        for (int n = 0; n < 100 && k < 3; n++) begin
            @(posedge ap_clk); #1;
            if (done_id) begin
                t_done[k] = n;
                k++;
                if (k == 3) ap_start = 1'b0;
            end
        end
        check("t5_held_ndone", k, 3);
        check("t5_period_a", t_done[1] - t_done[0], 20);
        check("t5_period_b", t_done[2] - t_done[1], 20);
        repeat (3) @(posedge ap_clk);
        #1;
        check("t5_held_stop_idle", idle_id, 1);

        // Reset asserted mid-MAC.
        @(posedge ap_clk); #1;
        x_in     = pack_x(21'h004000, 21'h004000, 21'h004000, 21'h004000);
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (7) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        #1;
        check("t6_rst_y_id", y_id, 0);
        check("t6_rst_y_bs", y_bs, 0);
        check("t6_rst_idle", idle_id, 1);
        check("t6_rst_done", done_id, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        nd_rst = 0;
        for (int n = 0; n < 25; n++) begin
            if (done_id) nd_rst++;
            @(posedge ap_clk); #1;
        end
        check("t6_no_done", nd_rst, 0);
        run(x_t1, -1, -1, -1, lat, nd, nrb);
        check("t6_latency", lat, 19);
        check("t6_id_y", y_id, {21'h001000, 21'h1F8000, 21'h006000});
        check("t6_bias", y_bs, {21'h000000, 21'h003000, 21'h1FE000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
